// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared ALU datapath constants and decrementer queue state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH   = 4;
  localparam int DEC_Q_DEPTH = 2;

  // Encoding equals the queue occupancy count.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } dec_q_state_e;

endpackage

`default_nettype wire

// File: rtl/dec_core.sv
// ============================================================================
// Module  : dec_core
// Brief   : Combinational decrement S = A - 1 with borrow-out.
//           Define DEC_SATURATE_EN to saturate A=0 to S=0 instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] S,
  output logic             B_out
);

  logic [WIDTH-1:0] w_diff;

  // A bit flips exactly when every lower bit is zero.
  assign w_diff[0] = ~A[0];

  for (genvar i = 1; i < WIDTH; i++) begin : g_bit
    assign w_diff[i] = A[i] ^ ~(|A[i-1:0]);
  end

  assign B_out = ~(|A);

`ifdef DEC_SATURATE_EN
  assign S = B_out ? '0 : w_diff;
`else
  assign S = w_diff;
`endif

endmodule

`default_nettype wire

// File: rtl/decrementer_pipe.sv
// ============================================================================
// Module  : decrementer_pipe
// Brief   : Decrementer with valid/ready input and a 2-entry output queue.
//           Honours DEC_SATURATE_EN via dec_core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module decrementer_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = DEC_Q_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             B_out
);

  localparam logic [1:0] c_FULL_CNT = 2'(DEPTH);

  dec_q_state_e     state_q, state_d;
  logic [WIDTH:0]   head_q, head_d;
  logic [WIDTH:0]   tail_q, tail_d;
  logic [WIDTH-1:0] w_core_s;
  logic             w_core_b;
  logic [WIDTH:0]   w_result;
  logic             w_push;
  logic             w_pop;

  dec_core #(
    .WIDTH (WIDTH)
  ) u_dec_core (
    .A     (A),
    .S     (w_core_s),
    .B_out (w_core_b)
  );

  assign w_result = {w_core_b, w_core_s};

  // Handshake flags come from registered state only; out_ready never reaches in_ready.
  assign in_ready  = (state_q != c_FULL_CNT);
  assign out_valid = (state_q != Q_EMPTY);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign S     = out_valid ? head_q[WIDTH-1:0] : '0;
  assign B_out = out_valid ? head_q[WIDTH]     : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Q_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      Q_EMPTY: begin
        if (w_push) begin
          head_d  = w_result;
          state_d = Q_ONE;
        end
      end
      Q_ONE: begin
        if (w_push && w_pop) begin
          head_d = w_result;
        end else if (w_push) begin
          tail_d  = w_result;
          state_d = Q_FULL;
        end else if (w_pop) begin
          state_d = Q_EMPTY;
        end
      end
      Q_FULL: begin
        if (w_pop) begin
          head_d  = tail_q;
          state_d = Q_ONE;
        end
      end
      default: state_d = Q_EMPTY;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_decrementer_pipe.sv
// ============================================================================
// Module  : tb_decrementer_pipe
// Brief   : Directed self-checking bench for decrementer_pipe.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decrementer_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] S;
  logic       B_out;

  int total = 0;
  int bad   = 0;

  decrementer_pipe #(
    .WIDTH (4),
    .DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .B_out     (B_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DEC_SATURATE_EN
  localparam logic [3:0] ZERO_RES = 4'h0;
`else
  localparam logic [3:0] ZERO_RES = 4'hF;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    A         = 4'h0;
    out_ready = 1'b0;

    // 1: reset, then a single operation
    step();
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_B", 32'(B_out), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b1; A = 4'b1010; out_ready = 1'b1;
    step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_S", 32'(S), 32'h9);
    chk("t1_B", 32'(B_out), 32'd0);
    in_valid = 1'b0;
    step();
    chk("t1_empty", 32'(out_valid), 32'd0);

    // 2: borrow / wrap, then A=F
    in_valid = 1'b1; A = 4'h0;
    step();
    chk("t2_zero_S", 32'(S), 32'(ZERO_RES));
    chk("t2_zero_B", 32'(B_out), 32'd1);
    A = 4'hF;
    step();
    chk("t2_f_S", 32'(S), 32'hE);
    chk("t2_f_B", 32'(B_out), 32'd0);
    in_valid = 1'b0;
    step();
    chk("t2_empty", 32'(out_valid), 32'd0);

    // 3: back-pressure fill and FIFO drain
    out_ready = 1'b0; in_valid = 1'b1; A = 4'b1011;
    step();
    chk("t3_rdy1", 32'(in_ready), 32'd1);
    chk("t3_head1", 32'(S), 32'hA);
    A = 4'b0110;
    step();
    chk("t3_full_rdy", 32'(in_ready), 32'd0);
    chk("t3_head2", 32'(S), 32'hA);
    A = 4'b0011;
    step();
    chk("t3_hold_rdy", 32'(in_ready), 32'd0);
    chk("t3_hold_S", 32'(S), 32'hA);
    chk("t3_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    chk("t3_out2", 32'(S), 32'h5);
    chk("t3_rdy_back", 32'(in_ready), 32'd1);
    step();
    chk("t3_out3", 32'(S), 32'h2);
    in_valid = 1'b0;
    step();
    chk("t3_empty", 32'(out_valid), 32'd0);

    // 4: simultaneous push/pop at occupancy one
    out_ready = 1'b0; in_valid = 1'b1; A = 4'b0101;
    step();
    chk("t4_head", 32'(S), 32'h4);
    out_ready = 1'b1; A = 4'b1000;
    step();
    chk("t4_S", 32'(S), 32'h7);
    chk("t4_B", 32'(B_out), 32'd0);
    chk("t4_rdy", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    step();
    chk("t4_no_dup", 32'(out_valid), 32'd0);

    // 5: streaming 15 down to 0
    out_ready = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      in_valid = 1'b1; A = 4'(i);
      step();
      chk("t5_rdy", 32'(in_ready), 32'd1);
      chk("t5_valid", 32'(out_valid), 32'd1);
      chk("t5_S", 32'(S), (i == 0) ? 32'(ZERO_RES) : 32'(i - 1));
      chk("t5_B", 32'(B_out), (i == 0) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    step();
    chk("t5_empty", 32'(out_valid), 32'd0);

    // 6: asynchronous reset while full
    out_ready = 1'b0; in_valid = 1'b1; A = 4'h7;
    step();
    A = 4'h9;
    step();
    chk("t6_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_rdy", 32'(in_ready), 32'd1);
    chk("t6_rst_S", 32'(S), 32'd0);
    step();
    rst_n = 1'b1; in_valid = 1'b1; A = 4'b0010;
    step();
    chk("t6_post_valid", 32'(out_valid), 32'd1);
    chk("t6_post_S", 32'(S), 32'h1);
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
